// File: rtl/ir_pkg.sv
// Shared definitions for the IR burst link: FSM state codes, default nominal
// timings and the tolerance-window helpers used by receiver and transmitter.
package ir_pkg;

   // Receiver FSM state codes
   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] LEAD_MARK  = 3'd1;
   localparam logic [2:0] LEAD_SPACE = 3'd2;
   localparam logic [2:0] BIT_MARK   = 3'd3;
   localparam logic [2:0] BIT_SPACE  = 3'd4;
   localparam logic [2:0] STOP_MARK  = 3'd5;

   typedef logic [2:0]  ir_state_t;
   typedef logic [15:0] width_t;      // measured pulse widths, in microseconds

   // Default nominal timings of the link (microseconds unless noted)
   localparam int DEF_CYCLES_PER_US   = 100;
   localparam int DEF_GLITCH_CYCLES   = 200;
   localparam int DEF_LEADER_MARK_US  = 9000;
   localparam int DEF_LEADER_SPACE_US = 4500;
   localparam int DEF_BIT_MARK_US     = 560;
   localparam int DEF_ZERO_SPACE_US   = 560;
   localparam int DEF_ONE_SPACE_US    = 1690;
   localparam int DEF_NUM_BITS        = 8;
   localparam int DEF_TOL_PCT         = 25;
   localparam int DEF_TIMEOUT_US      = 20000;

   // Lower acceptance bound of a window around a nominal width (truncating)
   function automatic width_t win_lo(input int nom, input int tol_pct);
      return width_t'((nom * (100 - tol_pct)) / 100);
   endfunction

   // Upper acceptance bound of a window around a nominal width (truncating)
   function automatic width_t win_hi(input int nom, input int tol_pct);
      return width_t'((nom * (100 + tol_pct)) / 100);
   endfunction

   // Inclusive window test
   function automatic logic in_window(input width_t w, input width_t lo, input width_t hi);
      return (w >= lo) && (w <= hi);
   endfunction

endpackage

// File: rtl/ir_glitch_filter.sv
// Input conditioning for the IR receiver pin: two-flop synchronizer,
// polarity normalisation (mark = 1) and a stable-count glitch filter.
// The filtered level only follows the raw input after GLITCH_CYCLES
// consecutive cycles of disagreement, so shorter pulses never get through.
// rise_out/fall_out are single-cycle pulses aligned with the level change.
module ir_glitch_filter
   import ir_pkg::*;
#(
   parameter int GLITCH_CYCLES = DEF_GLITCH_CYCLES,
   parameter bit ACTIVE_LOW    = 1'b1
)(
   input  logic clk_in,
   input  logic rst_in,
   input  logic raw_in,
   output logic level_out,
   output logic rise_out,
   output logic fall_out
);

   localparam int            CNT_W    = $clog2(GLITCH_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GLITCH_CYCLES - 1);
   // Raw pin level while no carrier is present; synchronizer resets to it
   localparam logic          RAW_IDLE = ACTIVE_LOW ? 1'b1 : 1'b0;

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mark_raw;

   // Synchronizer stage and polarity normalisation
   always_comb begin
      sync1_d  = raw_in;
      sync2_d  = sync1_q;
      mark_raw = ACTIVE_LOW ? ~sync2_q : sync2_q;
   end

   // Stable-count filter: flip the level once the input has disagreed long enough
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (mark_raw != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = mark_raw;
            rise_d  = mark_raw;
            fall_d  = ~mark_raw;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Filter state registers; the filtered level resets to space
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sync1_q <= RAW_IDLE;
         sync2_q <= RAW_IDLE;
         level_q <= 1'b0;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level_out = level_q;
   assign rise_out  = rise_q;
   assign fall_out  = fall_q;

endmodule

// File: rtl/ir_burst_receiver.sv
// Pulse-width-coded IR frame receiver. A frame is a leader mark/space,
// NUM_BITS bit cells (mark + space whose width codes the bit, LSB first)
// and a closing stop mark. Every mark/space width is measured in
// microseconds and judged against a tolerance window when it ends.
module ir_burst_receiver
   import ir_pkg::*;
#(
   parameter int CYCLES_PER_US   = DEF_CYCLES_PER_US,
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter int GLITCH_CYCLES   = DEF_GLITCH_CYCLES,
   parameter int LEADER_MARK_US  = DEF_LEADER_MARK_US,
   parameter int LEADER_SPACE_US = DEF_LEADER_SPACE_US,
   parameter int BIT_MARK_US     = DEF_BIT_MARK_US,
   parameter int ZERO_SPACE_US   = DEF_ZERO_SPACE_US,
   parameter int ONE_SPACE_US    = DEF_ONE_SPACE_US,
   parameter int NUM_BITS        = DEF_NUM_BITS,
   parameter int TOL_PCT         = DEF_TOL_PCT,
   parameter int TIMEOUT_US      = DEF_TIMEOUT_US
)(
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                ir_in,
   output logic [NUM_BITS-1:0] data_out,
   output logic                valid_out,
   output logic                error_out,
   output logic                busy_out
);

   // Acceptance windows, fixed at elaboration
   localparam width_t LM_LO = win_lo(LEADER_MARK_US, TOL_PCT);
   localparam width_t LM_HI = win_hi(LEADER_MARK_US, TOL_PCT);
   localparam width_t LS_LO = win_lo(LEADER_SPACE_US, TOL_PCT);
   localparam width_t LS_HI = win_hi(LEADER_SPACE_US, TOL_PCT);
   localparam width_t BM_LO = win_lo(BIT_MARK_US, TOL_PCT);
   localparam width_t BM_HI = win_hi(BIT_MARK_US, TOL_PCT);
   localparam width_t ZS_LO = win_lo(ZERO_SPACE_US, TOL_PCT);
   localparam width_t ZS_HI = win_hi(ZERO_SPACE_US, TOL_PCT);
   localparam width_t OS_LO = win_lo(ONE_SPACE_US, TOL_PCT);
   localparam width_t OS_HI = win_hi(ONE_SPACE_US, TOL_PCT);
   localparam width_t WIDTH_MAX = width_t'(TIMEOUT_US);

   localparam int                PRESC_W    = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CYCLES_PER_US - 1);
   localparam int                BCNT_W     = $clog2(NUM_BITS + 1);
   localparam logic [BCNT_W-1:0] BCNT_LAST  = BCNT_W'(NUM_BITS - 1);

   // Filtered input
   logic f_level, f_rise, f_fall;

   // Timebase
   logic [PRESC_W-1:0] presc_q, presc_d;
   width_t             width_q, width_d;
   width_t             width_inc;
   logic               us_tick;
   logic               lvl_edge, mark_end, space_end;

   // Frame decoding
   ir_state_t          state_q, state_d;
   logic [NUM_BITS-1:0] shift_q, shift_d;
   logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
   logic [NUM_BITS-1:0] data_q, data_d;
   logic               valid_q, valid_d;
   logic               error_q, error_d;
   logic               abort;
   logic               bit_ok;
   logic               bit_val;

   ir_glitch_filter #(
      .GLITCH_CYCLES (GLITCH_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW)
   ) u_filter (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .raw_in    (ir_in),
      .level_out (f_level),
      .rise_out  (f_rise),
      .fall_out  (f_fall)
   );

   // Prescaler and saturating width counter, both restarted by every filtered edge.
   // width_inc includes the tick of the current cycle, so an edge-to-edge
   // interval of exactly N us is judged as N.
   always_comb begin
      lvl_edge  = f_rise | f_fall;
      mark_end  = lvl_edge & ~f_level;
      space_end = lvl_edge & f_level;
      us_tick   = (presc_q == PRESC_LAST);
      presc_d   = (lvl_edge || us_tick) ? '0 : presc_q + PRESC_W'(1);
      width_inc = (us_tick && (width_q < WIDTH_MAX)) ? width_q + 16'd1 : width_q;
      width_d   = lvl_edge ? '0 : width_inc;
   end

   // Frame FSM: judge each mark/space on the edge that ends it
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bcnt_d  = bcnt_q;
      data_d  = data_q;
      valid_d = 1'b0;
      error_d = 1'b0;
      abort   = 1'b0;
      bit_ok  = 1'b0;
      bit_val = 1'b0;

      case (state_q)
         IDLE: begin
            // Only a fresh mark start arms the decoder; a mark already in
            // progress is ignored until it ends.
            if (space_end) state_d = LEAD_MARK;
         end
         LEAD_MARK: begin
            // A bad leader is treated as noise: back to idle without an error
            if (mark_end) begin
               state_d = in_window(width_inc, LM_LO, LM_HI) ? LEAD_SPACE : IDLE;
            end
         end
         LEAD_SPACE: begin
            if (space_end) begin
               if (in_window(width_inc, LS_LO, LS_HI)) state_d = BIT_MARK;
               else                                     abort   = 1'b1;
            end
         end
         BIT_MARK: begin
            if (mark_end) begin
               if (in_window(width_inc, BM_LO, BM_HI)) state_d = BIT_SPACE;
               else                                     abort   = 1'b1;
            end
         end
         BIT_SPACE: begin
            if (space_end) begin
               if (in_window(width_inc, ZS_LO, ZS_HI)) begin
                  bit_ok  = 1'b1;
                  bit_val = 1'b0;
               end else if (in_window(width_inc, OS_LO, OS_HI)) begin
                  bit_ok  = 1'b1;
                  bit_val = 1'b1;
               end else begin
                  abort = 1'b1;
               end
               if (bit_ok) begin
                  // LSB arrives first, so shift in from the top
                  shift_d = {bit_val, shift_q[NUM_BITS-1:1]};
                  if (bcnt_q == BCNT_LAST) begin
                     bcnt_d  = '0;
                     state_d = STOP_MARK;
                  end else begin
                     bcnt_d  = bcnt_q + BCNT_W'(1);
                     state_d = BIT_MARK;
                  end
               end
            end
         end
         STOP_MARK: begin
            if (mark_end) begin
               if (in_window(width_inc, BM_LO, BM_HI)) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  shift_d = '0;
                  state_d = IDLE;
               end else begin
                  abort = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A mark or space that has run to the limit kills the frame
      if ((state_q != IDLE) && (width_q >= WIDTH_MAX)) abort = 1'b1;

      if (abort) begin
         state_d = IDLE;
         shift_d = '0;
         bcnt_d  = '0;
         valid_d = 1'b0;
         error_d = 1'b1;
      end
   end

   // State, timebase and output registers
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         presc_q <= '0;
         width_q <= '0;
         state_q <= IDLE;
         shift_q <= '0;
         bcnt_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         presc_q <= presc_d;
         width_q <= width_d;
         state_q <= state_d;
         shift_q <= shift_d;
         bcnt_q  <= bcnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         error_q <= error_d;
      end
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign error_out = error_q;
   assign busy_out  = (state_q != IDLE);

endmodule

// File: tb/tb_ir_burst_receiver.sv
// Directed bench for ir_burst_receiver. Timings are scaled down so whole
// frames fit in a short run: 4 cycles per us, 8-cycle glitch filter and
// all nominal widths divided by 40 relative to the field link.
//   leader mark 225 us -> window 168..281   leader space 112 -> 84..140
//   bit mark 14 -> 10..17   zero space 14 -> 10..17   one space 42 -> 31..52
//   timeout 500 us
module tb_ir_burst_receiver;

   localparam int CPU = 4;
   localparam int LM  = 225;
   localparam int LS  = 112;
   localparam int BM  = 14;
   localparam int ZS  = 14;
   localparam int OS  = 42;
   localparam int TO  = 500;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b1;
   logic       ir_in  = 1'b1;
   logic [7:0] data_out;
   logic       valid_out;
   logic       error_out;
   logic       busy_out;

   int n_cmp = 0;
   int n_mis = 0;
   int valid_cnt = 0;
   int error_cnt = 0;
   int both_cnt  = 0;
   logic [7:0] hist [0:15];

   always #5 clk_in = ~clk_in;

   ir_burst_receiver #(
      .CYCLES_PER_US   (CPU),
      .ACTIVE_LOW      (1'b1),
      .GLITCH_CYCLES   (8),
      .LEADER_MARK_US  (LM),
      .LEADER_SPACE_US (LS),
      .BIT_MARK_US     (BM),
      .ZERO_SPACE_US   (ZS),
      .ONE_SPACE_US    (OS),
      .NUM_BITS        (8),
      .TOL_PCT         (25),
      .TIMEOUT_US      (TO)
   ) dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .ir_in     (ir_in),
      .data_out  (data_out),
      .valid_out (valid_out),
      .error_out (error_out),
      .busy_out  (busy_out)
   );

   // Pulse monitor, sampled away from the active edge
   always @(negedge clk_in) begin
      if (valid_out) begin
         hist[valid_cnt % 16] <= data_out;
         valid_cnt <= valid_cnt + 1;
      end
      if (error_out) error_cnt <= error_cnt + 1;
      if (valid_out && error_out) both_cnt <= both_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Hold raw level (0 = mark) for a number of cycles, starting at a negedge
   task automatic drive(input logic lvl, input int cycles);
      ir_in = lvl;
      repeat (cycles) @(negedge clk_in);
   endtask

   task automatic mark(input int us);
      drive(1'b0, us * CPU);
   endtask

   task automatic space(input int us);
      drive(1'b1, us * CPU);
   endtask

   // Full frame; odd_bit gets a space of odd_us, blip_bit gets a 4-cycle
   // raw mark blip 20 us into its space. Use -1 to disable either.
   task automatic send_frame(input logic [7:0] d, input int lead_us, input int odd_bit,
                             input int odd_us, input int blip_bit, input int gap_us);
      mark(lead_us);
      space(LS);
      for (int i = 0; i < 8; i++) begin
         int sp;
         mark(BM);
         sp = d[i] ? OS : ZS;
         if (i == odd_bit) sp = odd_us;
         if (i == blip_bit) begin
            drive(1'b1, 20 * CPU);
            drive(1'b0, 4);
            drive(1'b1, sp * CPU - 20 * CPU - 4);
         end else begin
            space(sp);
         end
      end
      mark(BM);
      space(gap_us);
      $display("frame %02h sent: lead %0d us, odd bit %0d (%0d us), blip bit %0d, gap %0d us",
               d, lead_us, odd_bit, odd_us, blip_bit, gap_us);
   endtask

   initial begin
      logic [7:0] part;

      // Reset state
      repeat (4) @(negedge clk_in);
      check("rst_data",  data_out, 8'h00);
      check("rst_valid", valid_out, 1'b0);
      check("rst_error", error_out, 1'b0);
      check("rst_busy",  busy_out, 1'b0);
      rst_in = 1'b0;
      space(20);

      // Short raw blip while idle must not arm the decoder
      drive(1'b0, 4);
      drive(1'b1, 40);
      $display("idle blip sent");
      check("blip_idle_busy", busy_out, 1'b0);
      check("blip_idle_err",  error_cnt, 0);

      // Nominal frame 0xA5
      send_frame(8'hA5, LM, -1, 0, -1, 30);
      check("a5_valid_cnt", valid_cnt, 1);
      check("a5_hist",      hist[0], 8'hA5);
      check("a5_data",      data_out, 8'hA5);
      check("a5_err",       error_cnt, 0);
      check("a5_busy",      busy_out, 1'b0);

      // Back-to-back 0x00 then 0xFF with a 10 us gap
      send_frame(8'h00, LM, -1, 0, -1, 10);
      send_frame(8'hFF, LM, -1, 0, -1, 30);
      check("b2b_valid_cnt", valid_cnt, 3);
      check("b2b_first",     hist[1], 8'h00);
      check("b2b_second",    hist[2], 8'hFF);
      check("b2b_data",      data_out, 8'hFF);
      check("b2b_err",       error_cnt, 0);

      // Blip inside a one-space of bit 1
      send_frame(8'h5A, LM, -1, 0, 1, 30);
      check("blip_valid_cnt", valid_cnt, 4);
      check("blip_hist",      hist[3], 8'h5A);
      check("blip_err",       error_cnt, 0);

      // Bit 3 space of 30 us falls between the zero and one windows
      send_frame(8'hC3, LM, 3, 30, -1, 30);
      check("gap3_err",       error_cnt, 1);
      check("gap3_valid_cnt", valid_cnt, 4);
      check("gap3_data",      data_out, 8'h5A);
      check("gap3_busy",      busy_out, 1'b0);

      // Short leader: silent return to idle
      mark(40);
      check("short_lead_busy_mid", busy_out, 1'b1);
      mark(35);
      space(100);
      $display("short leader (75 us) sent");
      check("short_lead_err",  error_cnt, 1);
      check("short_lead_busy", busy_out, 1'b0);

      // Stuck mark after a good leader: timeout error, mark then ignored
      mark(LM);
      space(LS);
      mark(600);
      check("stuck_busy_mid", busy_out, 1'b0);
      check("stuck_err_mid",  error_cnt, 2);
      mark(25);
      space(50);
      $display("stuck mark (625 us) sent");
      check("stuck_err",       error_cnt, 2);
      check("stuck_busy",      busy_out, 1'b0);
      check("stuck_valid_cnt", valid_cnt, 4);

      // Window edges: leader 168 (low bound) and one-space 52 (high bound) accepted
      send_frame(8'h81, 168, 0, 52, -1, 30);
      check("bound_valid_cnt", valid_cnt, 5);
      check("bound_hist",      hist[4], 8'h81);
      check("bound_err",       error_cnt, 2);

      // One-space of 53 us is just outside the window
      send_frame(8'h81, LM, 7, 53, -1, 30);
      check("over_err",       error_cnt, 3);
      check("over_valid_cnt", valid_cnt, 5);
      check("over_data",      data_out, 8'h81);

      // Leader of 167 us is just below the window: silent
      send_frame(8'h42, 167, -1, 0, -1, 30);
      check("under_lead_err",   error_cnt, 3);
      check("under_lead_valid", valid_cnt, 5);

      // Reset pulse during the mark of bit 5
      part = 8'h3C;
      mark(LM);
      space(LS);
      for (int i = 0; i < 5; i++) begin
         mark(BM);
         space(part[i] ? OS : ZS);
      end
      drive(1'b0, 20);
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b0;
      $display("reset pulsed during bit 5");
      check("midrst_data",  data_out, 8'h00);
      check("midrst_busy",  busy_out, 1'b0);
      check("midrst_valid", valid_out, 1'b0);
      check("midrst_error", error_out, 1'b0);
      drive(1'b0, BM * CPU - 21);
      space(100);
      check("midrst_err_cnt",   error_cnt, 3);
      check("midrst_valid_cnt", valid_cnt, 5);
      check("midrst_data_after", data_out, 8'h00);

      // Clean frame after the reset
      send_frame(8'h3C, LM, -1, 0, -1, 30);
      check("post_rst_valid_cnt", valid_cnt, 6);
      check("post_rst_hist",      hist[5], 8'h3C);
      check("post_rst_data",      data_out, 8'h3C);
      check("post_rst_err",       error_cnt, 3);

      check("valid_error_overlap", both_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
